// File: rtl/data_mem_dma.sv
// data_mem_dma: byte-block copy/fill initiator on the shared single-port data memory.
// Fill mode is compiled in only when DATA_MEM_DMA_FILL_EN is defined; otherwise every transfer is a copy.
module data_mem_dma (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       start,
    input  logic       fill,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill_value,
    input  logic       bus_grant,
    output logic       busy,
    output logic       done,
    output logic [7:0] Data_address,
    output logic       Data_read_en,
    output logic       Data_write_en,
    output logic [7:0] Data_memory_in,
    input  logic [7:0] Data_memory_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] s_q, s_d;
    logic [7:0] d_q, d_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic [7:0] fv_q, fv_d;
    logic [7:0] buf_q, buf_d;

    logic       fill_s;
    logic [7:0] fill_value_s;

`ifdef DATA_MEM_DMA_FILL_EN
    assign fill_s       = fill;
    assign fill_value_s = fill_value;
`else
    logic       unused_fill_s;
    assign fill_s        = 1'b0;
    assign fill_value_s  = 8'd0;
    assign unused_fill_s = ^{fill, fill_value};
`endif

    // State and datapath registers
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= 8'd0;
            d_q     <= 8'd0;
            cnt_q   <= 8'd0;
            mode_q  <= 1'b0;
            fv_q    <= 8'd0;
            buf_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fv_q    <= fv_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state and register update; a grant=0 cycle holds everything
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fv_d    = fv_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d    = src;
                    d_d    = dst;
                    mode_d = fill_s;
                    fv_d   = fill_value_s;
                    cnt_d  = len;
                    if (len == 8'd0) begin
                        state_d = ST_DONE;
                    end else if (fill_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (bus_grant) begin
                    buf_d   = Data_memory_out;
                    s_d     = s_q + 8'd1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (bus_grant) begin
                    d_d   = d_q + 8'd1;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_DONE;
                    end else if (mode_q) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-port and status outputs; enables follow bus_grant in the same cycle
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        Data_address   = 8'd0;
        Data_read_en   = 1'b0;
        Data_write_en  = 1'b0;
        Data_memory_in = 8'd0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_READ: begin
                busy         = 1'b1;
                Data_address = s_q;
                Data_read_en = bus_grant;
            end
            ST_WRITE: begin
                busy           = 1'b1;
                Data_address   = d_q;
                Data_write_en  = bus_grant;
                Data_memory_in = mode_q ? fv_q : buf_q;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
